// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with thresholds, occupancy count, sync clear and read strobe.
// Optional sticky OVERFLOW/UNDERFLOW flags: define FIFO_SYNC_FLEX_ERR_FLAGS_EN.
module fifo_sync_flex #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          CLR,
    input  logic                          WR_EN,
    input  logic [DATA_WIDTH-1:0]         DIN,
    input  logic                          RD_EN,
    output logic [DATA_WIDTH-1:0]         DOUT,
    output logic                          DOUT_VALID,
    output logic                          FULL,
    output logic                          EMPTY,
    output logic                          ALMOST_FULL,
    output logic                          ALMOST_EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT,
    output logic                          OVERFLOW,
    output logic                          UNDERFLOW
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_flex: FIFO_DEPTH must be a power of two >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
        $error("fifo_sync_flex: AFULL_THRESH out of range");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sync_flex: AEMPTY_THRESH out of range");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("fifo_sync_flex: DATA_WIDTH must be >= 1");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  wr_acc, rd_acc;

    always_comb begin
        wr_acc       = WR_EN & ~full_q & ~CLR;
        rd_acc       = RD_EN & ~empty_q & ~CLR;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = rd_acc;
        if (CLR) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                dout_d   = mem[rd_ptr_q];
            end
            if (wr_acc && !rd_acc) count_d = count_q + CW'(1);
            if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
        end
        // Flags come from the next count so they line up with COUNT.
        full_d   = (count_d == CW'(FIFO_DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CW'(AFULL_THRESH));
        aempty_d = (count_d <= CW'(AEMPTY_THRESH));
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) mem[wr_ptr_q] <= DIN;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            afull_q      <= 1'b0;
            aempty_q     <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            afull_q      <= afull_d;
            aempty_q     <= aempty_d;
        end
    end

`ifdef FIFO_SYNC_FLEX_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = CLR ? 1'b0 : (ovf_q | (WR_EN & full_q));
        udf_d = CLR ? 1'b0 : (udf_q | (RD_EN & empty_q));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = udf_q;
`else
    assign OVERFLOW  = 1'b0;
    assign UNDERFLOW = 1'b0;
`endif

    assign DOUT         = dout_q;
    assign DOUT_VALID   = dout_valid_q;
    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = afull_q;
    assign ALMOST_EMPTY = aempty_q;
    assign COUNT        = count_q;

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Directed bench for fifo_sync_flex at default parameters (16 x 8, AF=14, AE=2).
// Error-flag expectations follow FIFO_SYNC_FLEX_ERR_FLAGS_EN.
module tb_fifo_sync_flex;

    localparam int DEPTH = 16;
`ifdef FIFO_SYNC_FLEX_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       CLR = 1'b0;
    logic       WR_EN = 1'b0;
    logic       RD_EN = 1'b0;
    logic [7:0] DIN = '0;
    logic [7:0] DOUT;
    logic       DOUT_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
    logic [4:0] COUNT;
    logic       OVERFLOW, UNDERFLOW;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_sync_flex dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR),
        .WR_EN(WR_EN), .DIN(DIN), .RD_EN(RD_EN),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
        .FULL(FULL), .EMPTY(EMPTY),
        .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
        .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       clr, wr, rd;
        logic [7:0] din;
        int         cnt;
        logic       chk_d;
        logic [7:0] dout;
        logic       dv;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Flag expectations derived from occupancy and the default thresholds.
    task automatic chk_flags(input string nm, input int cnt);
        chk({nm, ".count"}, 32'(COUNT), 32'(cnt));
        chk({nm, ".full"}, 32'(FULL), 32'(cnt == DEPTH));
        chk({nm, ".empty"}, 32'(EMPTY), 32'(cnt == 0));
        chk({nm, ".afull"}, 32'(ALMOST_FULL), 32'(cnt >= DEPTH - 2));
        chk({nm, ".aempty"}, 32'(ALMOST_EMPTY), 32'(cnt <= 2));
    endtask

    task automatic step(input logic c, input logic w, input logic r, input logic [7:0] d);
        CLR = c; WR_EN = w; RD_EN = r; DIN = d;
        @(posedge CLK);
        #1;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_d;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'hA0, 1, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'hA0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'hB1, 1, 1'b1, 8'hA0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'hB2, 2, 1'b1, 8'hA0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'hB3, 3, 1'b1, 8'hA0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'hB4, 4, 1'b1, 8'hA0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'hB5, 5, 1'b1, 8'hA0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'hC0, 0, 1'b1, 8'hA0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'hA0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'hD0, 1, 1'b1, 8'hA0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'hD0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'hD0, 1'b0};

        // Reset state, held and after release
        repeat (2) @(posedge CLK);
        #1;
        chk_flags("rst", 0);
        chk("rst.dout", 32'(DOUT), 32'h0);
        chk("rst.dv", 32'(DOUT_VALID), 32'h0);
        chk("rst.ovf", 32'(OVERFLOW), 32'h0);
        chk("rst.udf", 32'(UNDERFLOW), 32'h0);
        RST_N = 1'b1;
        step(0, 0, 0, 8'h00);
        chk_flags("idle", 0);
        chk("idle.dv", 32'(DOUT_VALID), 32'h0);

        // Fill to full, then drain in order
        for (int i = 1; i <= DEPTH; i++) begin
            step(0, 1, 0, 8'(i));
            chk_flags($sformatf("fill%0d", i), i);
            chk("fill.dv", 32'(DOUT_VALID), 32'h0);
        end
        for (int j = 1; j <= DEPTH; j++) begin
            step(0, 0, 1, 8'h00);
            chk($sformatf("drain%0d.dout", j), 32'(DOUT), 32'(j));
            chk("drain.dv", 32'(DOUT_VALID), 32'h1);
            chk_flags($sformatf("drain%0d", j), DEPTH - j);
        end
        step(0, 0, 0, 8'h00);
        chk("drained.dv", 32'(DOUT_VALID), 32'h0);
        chk("drained.dout", 32'(DOUT), 32'h10);
        chk_flags("drained", 0);

        // Steady simultaneous read/write at half occupancy, across wrap
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 8'(8'h20 + i));
            q.push_back(8'(8'h20 + i));
        end
        chk_flags("half", 8);
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 1, 8'(8'h28 + k));
            exp_d = q.pop_front();
            q.push_back(8'(8'h28 + k));
            chk($sformatf("rw%0d.dout", k), 32'(DOUT), 32'(exp_d));
            chk("rw.dv", 32'(DOUT_VALID), 32'h1);
            chk_flags($sformatf("rw%0d", k), 8);
        end
        step(1, 0, 0, 8'h00);
        q.delete();
        chk_flags("clr1", 0);
        chk("clr1.dv", 32'(DOUT_VALID), 32'h0);

        // Table: both-on-empty, clear with write pending, pointer reset
        for (int v = 0; v < 12; v++) begin
            step(tbl[v].clr, tbl[v].wr, tbl[v].rd, tbl[v].din);
            chk_flags($sformatf("vec%0d", v), tbl[v].cnt);
            chk($sformatf("vec%0d.dv", v), 32'(DOUT_VALID), 32'(tbl[v].dv));
            if (tbl[v].chk_d)
                chk($sformatf("vec%0d.dout", v), 32'(DOUT), 32'(tbl[v].dout));
        end

        // Both requests while full: read only, write dropped
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(8'h40 + i));
        chk_flags("full", DEPTH);
        step(0, 1, 1, 8'hEE);
        chk("fullrw.dout", 32'(DOUT), 32'h40);
        chk("fullrw.dv", 32'(DOUT_VALID), 32'h1);
        chk_flags("fullrw", DEPTH - 1);
        for (int i = 1; i < DEPTH; i++) begin
            step(0, 0, 1, 8'h00);
            chk($sformatf("post%0d.dout", i), 32'(DOUT), 32'(8'h40 + i));
            chk_flags($sformatf("post%0d", i), DEPTH - 1 - i);
        end
        step(0, 0, 1, 8'h00);
        chk("empty_rd.dv", 32'(DOUT_VALID), 32'h0);
        chk("empty_rd.dout", 32'(DOUT), 32'h4F);
        chk_flags("empty_rd", 0);

        // Sticky error flags
        step(1, 0, 0, 8'h00);
        chk("err.clr.ovf", 32'(OVERFLOW), 32'h0);
        chk("err.clr.udf", 32'(UNDERFLOW), 32'h0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(8'h60 + i));
        chk("err.fill.ovf", 32'(OVERFLOW), 32'h0);
        step(0, 1, 0, 8'h99);
        chk("err.ovf", 32'(OVERFLOW), 32'(ERR_EN));
        chk_flags("err.ovf", DEPTH);
        step(0, 0, 0, 8'h00);
        chk("err.ovf_hold", 32'(OVERFLOW), 32'(ERR_EN));
        step(1, 0, 0, 8'h00);
        chk("err.ovf_clr", 32'(OVERFLOW), 32'h0);
        chk_flags("err.clr2", 0);
        step(0, 0, 1, 8'h00);
        chk("err.udf", 32'(UNDERFLOW), 32'(ERR_EN));
        chk("err.udf.dv", 32'(DOUT_VALID), 32'h0);
        step(0, 0, 0, 8'h00);
        chk("err.udf_hold", 32'(UNDERFLOW), 32'(ERR_EN));
        step(1, 0, 0, 8'h00);
        chk("err.udf_clr", 32'(UNDERFLOW), 32'h0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'h70 + i));
        step(0, 0, 1, 8'h00);
        chk("pre_rst.dout", 32'(DOUT), 32'h70);
        chk("pre_rst.dv", 32'(DOUT_VALID), 32'h1);
        WR_EN = 1'b1; RD_EN = 1'b1; DIN = 8'h55;
        #2;
        RST_N = 1'b0;
        #1;
        chk_flags("arst", 0);
        chk("arst.dout", 32'(DOUT), 32'h0);
        chk("arst.dv", 32'(DOUT_VALID), 32'h0);
        WR_EN = 1'b0; RD_EN = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        step(0, 0, 0, 8'h00);
        chk_flags("arst.idle", 0);
        chk("arst.idle.dv", 32'(DOUT_VALID), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flex.md
Name: fifo_sync_flex

Overview:
Parametrised synchronous single-clock FIFO, the next generation of the team's basic FIFO. It adds:
- simultaneous read and write in the same cycle
- programmable almost-full and almost-empty thresholds
- an occupancy count output
- a synchronous clear
- a read-data-valid strobe

It sits between a producer and a consumer in one clock domain, and both sides use flag-based flow control.

Parameters:
DATA_WIDTH, 8, data bus width in bits (≥1).
FIFO_DEPTH, 16, number of entries; must be a power of two, ≥2.
AFULL_THRESH, FIFO_DEPTH-2, ALMOST_FULL is asserted when count ≥ AFULL_THRESH (1..FIFO_DEPTH).
AEMPTY_THRESH, 2, ALMOST_EMPTY is asserted when count ≤ AEMPTY_THRESH (0..FIFO_DEPTH-1).

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  reset, asynchronous, active-low.
CLR  in  1  synchronous clear; empties the FIFO and has priority over WR_EN/RD_EN.
WR_EN  in  1  write request.
DIN  in  DATA_WIDTH  write data.
RD_EN  in  1  read request.
DOUT  out  DATA_WIDTH  registered read data.
DOUT_VALID  out  1  one-cycle strobe; DOUT holds newly read data.
FULL  out  1  count == FIFO_DEPTH.
EMPTY  out  1  count == 0.
ALMOST_FULL  out  1  count ≥ AFULL_THRESH.
ALMOST_EMPTY  out  1  count ≤ AEMPTY_THRESH.
COUNT  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
OVERFLOW  out  1  sticky write-when-full error (see Optional Feature).
UNDERFLOW  out  1  sticky read-when-empty error (see Optional Feature).

Behaviour:
- Reset (RST_N low, asynchronous) values:
  - pointers = 0, COUNT = 0, DOUT = 0, DOUT_VALID = 0
  - EMPTY = 1, ALMOST_EMPTY = 1, FULL = 0, ALMOST_FULL = 0
  - OVERFLOW = 0, UNDERFLOW = 0
  - Memory contents are not reset.
- Accepts:
  - wr_acc = WR_EN & !FULL
  - rd_acc = RD_EN & !EMPTY
  - Both are evaluated on the state registered before the edge.
- Write: on wr_acc, DIN is stored at wr_ptr and wr_ptr increments modulo FIFO_DEPTH (natural wrap, log2 bits).
- Read:
  - On rd_acc, DOUT <= mem[rd_ptr], rd_ptr increments modulo FIFO_DEPTH, and DOUT_VALID = 1 for the following cycle.
  - Read latency is 1 cycle from request edge to data.
  - With no rd_acc, DOUT holds its last value and DOUT_VALID = 0.
- COUNT next value: +1 on wr_acc only, −1 on rd_acc only, unchanged when both or neither.
- Simultaneous WR_EN and RD_EN:
  - When 0 < COUNT < FIFO_DEPTH, both are accepted and COUNT is unchanged.
  - When EMPTY, only the write is accepted; there is no bypass, and the data becomes readable from the next cycle.
  - When FULL, only the read is accepted; the write is dropped.
- Flag timing: all flags are registered and computed from the next COUNT, so they are coherent with COUNT on the same cycle with no extra lag.
- CLR high at an edge:
  - pointers and COUNT become 0, EMPTY = 1, ALMOST_EMPTY = 1, FULL = 0, ALMOST_FULL = 0, DOUT_VALID = 0
  - DOUT holds its value; OVERFLOW/UNDERFLOW are also cleared
  - WR_EN/RD_EN are ignored that cycle.
- Reset asserted mid-operation returns every output to its reset value immediately. Data in flight is lost.
- Invalid parameters (non-power-of-two depth, thresholds out of range) are flagged by an elaboration-time $error.

Optional Feature:
Macro FIFO_SYNC_FLEX_ERR_FLAGS_EN.
- Defined:
  - OVERFLOW is set on any cycle with WR_EN & FULL & !CLR.
  - UNDERFLOW is set on any cycle with RD_EN & EMPTY & !CLR.
  - Both are sticky until CLR or reset.
- Not defined: OVERFLOW and UNDERFLOW are tied to 0 and no error logic is built.
- FIFO data behaviour is identical either way.

Test Plan:
1. Reset, then idle → EMPTY=1, ALMOST_EMPTY=1, COUNT=0, DOUT=0, DOUT_VALID=0, FULL=0.
2. Write 0x01..0x10 (16 writes), then read 16 times →
   - FULL=1 after the 16th write, ALMOST_FULL=1 from COUNT=14
   - DOUT yields 0x01..0x10 in order, DOUT_VALID high on each of the 16 cycles
   - EMPTY=1 at the end.
3. Fill 8 entries, then hold WR_EN=RD_EN=1 for 20 cycles with incrementing DIN → COUNT stays 8, ordering is preserved across pointer wrap, with no flag toggles.
4. EMPTY with WR_EN=RD_EN=1 → write accepted, COUNT=1, DOUT_VALID=0. FULL with both high → COUNT=15, DIN dropped, FULL=0.
5. Fill 5 entries, then CLR=1 with WR_EN=1 → COUNT=0, EMPTY=1. The next read request gives DOUT_VALID=0.
6. With FIFO_SYNC_FLEX_ERR_FLAGS_EN defined:
   - Write when FULL → OVERFLOW=1 and held.
   - Read when EMPTY → UNDERFLOW=1.
   - CLR clears both.
   - Without the macro, both stay 0.
